// File: rtl/arbitro_memoria.sv
// arbitro_memoria: two-port round-robin arbiter and access sequencer for the
// 256x11 data memory (synchronous write, combinational read).
//
// Each access takes two cycles. In IDLE a request is granted and its
// addr/din/we are latched into the registered memory port. During SERVE the
// memory sees that address, and a write commits at the closing edge. At that
// same edge the winner gets a one-cycle ack, plus read data if it was a read.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0/we0/addr0/din0        port 0 request, 1 = write, address, write data
//   ack0, rdata0               port 0 completion pulse, read data
//   req1/we1/addr1/din1        port 1 request, 1 = write, address, write data
//   ack1, rdata1               port 1 completion pulse, read data
//   mem_addr/mem_din/mem_we    registered drive into the memory
//   mem_dout                   memory read data (combinational in mem_addr)
//   busy                       high while an access is in SERVE
module arbitro_memoria #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] din0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  localparam logic IDLE  = 1'b0;
  localparam logic SERVE = 1'b1;

  logic          state_q, state_d;
  logic          prio_q, prio_d;
  logic          winner_q, winner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          we_q, we_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic gnt_valid;
  logic gnt_sel;

  always_comb begin
    gnt_valid = req0 | req1;
    // Ties go to the priority port; a lone request wins outright.
    gnt_sel   = (req0 && req1) ? prio_q : req1;

    state_d  = state_q;
    prio_d   = prio_q;
    winner_d = winner_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = we_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d  = SERVE;
          winner_d = gnt_sel;
          prio_d   = ~gnt_sel;
          addr_d   = gnt_sel ? addr1 : addr0;
          din_d    = gnt_sel ? din1  : din0;
          we_d     = gnt_sel ? we1   : we0;
        end
      end
      SERVE: begin
        state_d = IDLE;
        we_d    = 1'b0;
        if (winner_q) begin
          ack1_d = 1'b1;
          if (!we_q) rdata1_d = mem_dout;
        end else begin
          ack0_d = 1'b1;
          if (!we_q) rdata0_d = mem_dout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      winner_q <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      winner_q <= winner_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_we   = we_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign busy     = (state_q == SERVE);

endmodule
